// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main memory between I-fill, D-fill and D write-through.
// Sequences block fills, steers returned words to the owning cache, drives stalls.
module mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LAT         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_data_we,
  output logic              i_tag_we,
  output logic              d_data_we,
  output logic              d_tag_we,
  output logic              wr_ack,
  output logic              i_stall,
  output logic              d_stall,
  output logic              busy
);

  localparam int CNT_W  = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK * 2);
  localparam int PEND_W = $clog2(MEM_LAT + 2);

  localparam logic [CNT_W-1:0] N_WORDS =
    CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_W =
    CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL_D,
    FILL_I,
    WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              i_first_q, i_first_d;

  logic              in_fi;
  logic              in_fd;
  logic              in_wr;
  logic              in_fill;
  logic              issue;
  logic              accept;
  logic              last_ret;
  logic              op_done;
  logic              eval;
  logic              ci;
  logic              cd;
  logic              cw;
  logic              first_eff;
  state_e            grant;
  logic [ADDR_W-1:0] grant_addr;

  // Decode the current operation owner.
  always_comb begin
    in_fi = 1'b0;
    in_fd = 1'b0;
    in_wr = 1'b0;
    unique case (state_q)
      IDLE:   ;
      FILL_I: in_fi = 1'b1;
      FILL_D: in_fd = 1'b1;
      WRITE:  in_wr = 1'b1;
    endcase
  end

  // Memory port, fill steering and stall outputs.
  always_comb begin
    in_fill  = in_fi | in_fd;
    issue    = in_fill & (issue_cnt_q < N_WORDS);
    // Returns only count while reads of this fill are in flight,
    // so stale data from before a reset can never be written.
    accept   = in_fill & mem_data_valid
             & (pend_q != '0);
    last_ret = accept & (ret_cnt_q == LAST_W);
    op_done  = last_ret | in_wr;

    mem_en    = issue | in_wr;
    mem_wr    = in_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_addr = '0;
    if (issue) begin
      mem_addr = base_q
               + (ADDR_W'(issue_cnt_q) << 1);
    end else if (in_wr) begin
      mem_addr = d_wr_addr;
    end
    if (in_wr) begin
      mem_wdata = d_wr_data;
    end
    if (accept) begin
      fill_addr = base_q
                + (ADDR_W'(ret_cnt_q) << 1);
    end

    i_data_we = accept & in_fi;
    i_tag_we  = last_ret & in_fi;
    d_data_we = accept & in_fd;
    d_tag_we  = last_ret & in_fd;
    wr_ack    = in_wr;
    busy      = (state_q != IDLE);

    i_stall = i_miss & ~i_tag_we;
    d_stall = (d_miss & ~d_tag_we)
            | (d_wr_req & ~wr_ack);
  end

  // Grant selection, counters and fairness flag.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    pend_d      = pend_q;
    i_first_d   = i_first_q;

    if (issue) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
    end
    if (accept) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
    end
    if (issue && !accept) begin
      pend_d = pend_q + 1'b1;
    end else if (!issue && accept) begin
      pend_d = pend_q - 1'b1;
    end

    eval = (state_q == IDLE) | op_done;

    // The completing requester sits out this grant:
    // its miss is still high until the cache sees tag_we.
    ci = i_miss & ~in_fi;
    cd = d_miss & ~in_fd;
    cw = d_wr_req & ~in_wr;

    // A D-side op finishing with an I-miss waiting
    // hands the very next grant to the I-fill.
    first_eff = i_first_q
              | (op_done & ~in_fi & i_miss);

    grant      = IDLE;
    grant_addr = '0;
    if (first_eff && ci) begin
      grant      = FILL_I;
      grant_addr = i_miss_addr;
    end else if (cd) begin
      grant      = FILL_D;
      grant_addr = d_miss_addr;
    end else if (cw) begin
      grant      = WRITE;
      grant_addr = d_wr_addr;
    end else if (ci) begin
      grant      = FILL_I;
      grant_addr = i_miss_addr;
    end

    if (eval) begin
      state_d   = grant;
      i_first_d = first_eff & (grant != FILL_I);
      if (grant != IDLE) begin
        base_d      = grant_addr & ~OFF_MASK;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        pend_d      = '0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      pend_q      <= '0;
      i_first_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      pend_q      <= pend_d;
      i_first_q   <= i_first_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level model
// checked every cycle, plus literal spot checks.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int W   = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_miss;
  logic [AW-1:0] i_miss_addr;
  logic          d_miss;
  logic [AW-1:0] d_miss_addr;
  logic          d_wr_req;
  logic [AW-1:0] d_wr_addr;
  logic [DW-1:0] d_wr_data;
  logic          mem_data_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] fill_addr;
  logic          i_data_we;
  logic          i_tag_we;
  logic          d_data_we;
  logic          d_tag_we;
  logic          wr_ack;
  logic          i_stall;
  logic          d_stall;
  logic          busy;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WORDS_PER_BLOCK(W),
    .MEM_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_miss(i_miss),
    .i_miss_addr(i_miss_addr),
    .d_miss(d_miss),
    .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req),
    .d_wr_addr(d_wr_addr),
    .d_wr_data(d_wr_data),
    .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_en(mem_en),
    .mem_wr(mem_wr),
    .fill_addr(fill_addr),
    .i_data_we(i_data_we),
    .i_tag_we(i_tag_we),
    .d_data_we(d_data_we),
    .d_tag_we(d_tag_we),
    .wr_ack(wr_ack),
    .i_stall(i_stall),
    .d_stall(d_stall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm,
                      input int act,
                      input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory: a read issued in cycle c returns valid in cycle c+LAT.
  // Not reset, so reads in flight at reset still come back.
  logic [LAT-1:0] rd_sr = '0;
  always @(posedge clk) begin
    mem_data_valid <= rd_sr[LAT-2];
    rd_sr <= {rd_sr[LAT-2:0], mem_en & ~mem_wr};
  end

  // Transaction-level model: an op is a kind, a base and the
  // number of cycles since it started.
  typedef enum int {M_IDLE, M_FI, M_FD, M_WR} mop_e;
  mop_e        m_op    = M_IDLE;
  int          m_t     = 0;
  bit          m_first = 1'b0;
  logic [15:0] m_base  = '0;

  always @(negedge clk) begin
    logic e_en, e_wr, e_ack, e_busy, e_fwe;
    logic e_idwe, e_itag, e_ddwe, e_dtag;
    logic [15:0] e_addr, e_wdata, e_faddr;
    bit done, ci, cd, cw;
    mop_e nxt;
    logic [15:0] naddr;

    if (!rst_n) begin
      m_op    = M_IDLE;
      m_t     = 0;
      m_first = 1'b0;
    end

    e_en = 0; e_wr = 0; e_ack = 0; e_fwe = 0;
    e_idwe = 0; e_itag = 0; e_ddwe = 0; e_dtag = 0;
    e_addr = '0; e_wdata = '0; e_faddr = '0;
    if (m_op == M_FI || m_op == M_FD) begin
      e_en    = (m_t < W);
      e_addr  = m_base + 16'(2 * m_t);
      e_fwe   = (m_t >= LAT) && (m_t < W + LAT);
      e_faddr = m_base + 16'(2 * (m_t - LAT));
      if (m_op == M_FI) begin
        e_idwe = e_fwe;
        e_itag = (m_t == W + LAT - 1);
      end else begin
        e_ddwe = e_fwe;
        e_dtag = (m_t == W + LAT - 1);
      end
    end else if (m_op == M_WR) begin
      e_en    = 1;
      e_wr    = 1;
      e_ack   = 1;
      e_addr  = d_wr_addr;
      e_wdata = d_wr_data;
    end
    e_busy = (m_op != M_IDLE);

    chk1("mem_en", mem_en, e_en);
    chk1("mem_wr", mem_wr, e_wr);
    if (e_en) chk16("mem_addr", mem_addr, e_addr);
    if (e_wr) chk16("mem_wdata", mem_wdata, e_wdata);
    if (e_fwe) chk16("fill_addr", fill_addr, e_faddr);
    chk1("i_data_we", i_data_we, e_idwe);
    chk1("i_tag_we", i_tag_we, e_itag);
    chk1("d_data_we", d_data_we, e_ddwe);
    chk1("d_tag_we", d_tag_we, e_dtag);
    chk1("wr_ack", wr_ack, e_ack);
    chk1("busy", busy, e_busy);
    chk1("i_stall", i_stall, i_miss & ~e_itag);
    chk1("d_stall", d_stall,
         (d_miss & ~e_dtag) | (d_wr_req & ~e_ack));

    if (rst_n) begin
      done = (m_op == M_WR)
          || ((m_op == M_FI || m_op == M_FD)
              && m_t == W + LAT - 1);
      if (m_op == M_IDLE || done) begin
        ci = i_miss && m_op != M_FI;
        cd = d_miss && m_op != M_FD;
        cw = d_wr_req && m_op != M_WR;
        if (done && m_op != M_FI && i_miss) m_first = 1;
        nxt = M_IDLE;
        naddr = '0;
        if (m_first && ci) begin
          nxt = M_FI; naddr = i_miss_addr;
        end else if (cd) begin
          nxt = M_FD; naddr = d_miss_addr;
        end else if (cw) begin
          nxt = M_WR; naddr = d_wr_addr;
        end else if (ci) begin
          nxt = M_FI; naddr = i_miss_addr;
        end
        if (nxt == M_FI) m_first = 0;
        m_base = naddr & 16'hFFF0;
        m_op = nxt;
        m_t = 0;
      end else begin
        m_t++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dcnt;
    logic seen;

    rst_n = 0;
    i_miss = 0; i_miss_addr = '0;
    d_miss = 0; d_miss_addr = '0;
    d_wr_req = 0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_en", mem_en, 1'b0);
    rst_n = 1;
    cyc(); cyc();

    // 1: lone I-miss
    i_miss = 1; i_miss_addr = 16'h1234;
    #1;
    chk1("t1_stall_req", i_stall, 1'b1);
    cnt = 0; dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) chk16("t1_a0", mem_addr, 16'h1230);
      if (k == 7) chk16("t1_a7", mem_addr, 16'h123E);
      cnt += int'(i_data_we);
      dcnt += int'(d_data_we | d_tag_we);
    end
    chk1("t1_tag12", i_tag_we, 1'b1);
    chk1("t1_stall_fall", i_stall, 1'b0);
    chk16("t1_flast", fill_addr, 16'h123E);
    chki("t1_dwe_cnt", cnt, 8);
    chki("t1_d_en", dcnt, 0);
    cyc(); i_miss = 0;
    cyc();
    chk1("t1_idle", busy, 1'b0);

    // 2: simultaneous I and D miss
    i_miss = 1; i_miss_addr = 16'h0100;
    d_miss = 1; d_miss_addr = 16'h2008;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) chk16("t2_d0", mem_addr, 16'h2000);
      if (k == 7) chk16("t2_d7", mem_addr, 16'h200E);
    end
    chk1("t2_dtag", d_tag_we, 1'b1);
    cyc(); d_miss = 0;
    chk16("t2_i0", mem_addr, 16'h0100);
    for (int k = 1; k < 12; k++) cyc();
    chk1("t2_itag", i_tag_we, 1'b1);
    cyc(); i_miss = 0;

    // 3: write raised during a fill waits
    i_miss = 1; i_miss_addr = 16'h0100;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      seen |= mem_wr;
      if (k == 3) begin
        d_wr_req = 1;
        d_wr_addr = 16'h0040;
        d_wr_data = 16'hBEEF;
      end
    end
    chk1("t3_no_wr", seen, 1'b0);
    chk1("t3_itag", i_tag_we, 1'b1);
    cyc(); i_miss = 0;
    chk1("t3_wr", mem_wr, 1'b1);
    chk16("t3_waddr", mem_addr, 16'h0040);
    chk16("t3_wdata", mem_wdata, 16'hBEEF);
    chk1("t3_ack", wr_ack, 1'b1);
    cyc(); d_wr_req = 0;
    chk1("t3_ack_off", wr_ack, 1'b0);

    // 4: I-miss gets in after at most one D op
    i_miss = 1; i_miss_addr = 16'h0300;
    d_miss = 1; d_miss_addr = 16'h4010;
    d_wr_req = 1; d_wr_addr = 16'h0050;
    d_wr_data = 16'h1234;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) chk16("t4_d0", mem_addr, 16'h4010);
    end
    chk1("t4_dtag", d_tag_we, 1'b1);
    cyc(); d_miss_addr = 16'h4020;
    chk16("t4_i_next", mem_addr, 16'h0300);
    chk1("t4_no_wr", mem_wr, 1'b0);
    for (int k = 1; k < 12; k++) cyc();
    chk1("t4_itag", i_tag_we, 1'b1);
    cyc(); i_miss = 0;
    chk16("t4_d2", mem_addr, 16'h4020);
    for (int k = 1; k < 12; k++) cyc();
    chk1("t4_dtag2", d_tag_we, 1'b1);
    cyc(); d_miss = 0;
    chk1("t4_ack", wr_ack, 1'b1);
    chk16("t4_waddr", mem_addr, 16'h0050);
    cyc(); d_wr_req = 0;
    chk1("t4_idle", busy, 1'b0);

    // 5: reset in the middle of a D fill
    d_miss = 1; d_miss_addr = 16'h5000;
    for (int k = 0; k < 7; k++) cyc();
    d_miss = 0; rst_n = 0;
    #1;
    chk1("t5_en", mem_en, 1'b0);
    chk16("t5_addr", mem_addr, 16'h0000);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_dwe", d_data_we, 1'b0);
    cyc(); cyc();
    rst_n = 1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      cnt += int'(i_data_we | i_tag_we
                  | d_data_we | d_tag_we);
    end
    chki("t5_stale_we", cnt, 0);
    chk1("t5_idle", busy, 1'b0);

    // 6: write from idle
    d_wr_req = 1; d_wr_addr = 16'h0080;
    d_wr_data = 16'hA5A5;
    #1;
    chk1("t6_stall", d_stall, 1'b1);
    cyc();
    chk1("t6_ack", wr_ack, 1'b1);
    chk1("t6_stall_off", d_stall, 1'b0);
    chk16("t6_wdata", mem_wdata, 16'hA5A5);
    cyc(); d_wr_req = 0;
    chk1("t6_ack_once", wr_ack, 1'b0);
    chk1("t6_idle", busy, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared main memory (MEM_LAT-cycle read latency, 16-bit words) among three requesters:
  - I-cache miss fill
  - D-cache miss fill
  - D-side write-through
- Owns the block-fill sequencing: issues word reads, steers returned data and the data/tag write enables to the owning cache, and drives the stall signals.
- Sits between both caches and the memory; replaces ad-hoc miss muxing in the cache top level.

Parameters:
- ADDR_W, 16, address width (byte addresses)
- DATA_W, 16, memory word width
- WORDS_PER_BLOCK, 8, words per cache block (block = 16 bytes)
- MEM_LAT, 4, cycles from mem_en to mem_data_valid

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss pending (level, held until serviced)
- i_miss_addr  in  ADDR_W  I-miss byte address
- d_miss  in  1  D-cache miss pending (level)
- d_miss_addr  in  ADDR_W  D-miss byte address
- d_wr_req  in  1  D write-through request (level, held until wr_ack)
- d_wr_addr  in  ADDR_W  write address
- d_wr_data  in  DATA_W  write data
- mem_data_valid  in  1  memory read data valid
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write (valid with mem_en)
- fill_addr  out  ADDR_W  cache array write address for the returning word
- i_data_we  out  1  I-cache data array write enable
- i_tag_we  out  1  I-cache tag write enable
- d_data_we  out  1  D-cache data array write enable
- d_tag_we  out  1  D-cache tag write enable
- wr_ack  out  1  write-through accepted (one-cycle pulse)
- i_stall  out  1  IF stall
- d_stall  out  1  MEM stall
- busy  out  1  not IDLE

Behaviour:

States: IDLE, FILL_D, FILL_I, WRITE. State is registered. Reset (async, rst_n=0) forces:
- state to IDLE
- all counters and the fairness flag to 0
- every registered output to 0: mem_*, *_we, wr_ack, busy

Grant (evaluated in IDLE and at the completing cycle of any operation; takes effect at the next edge), in priority order:
1. If i_first=1 and i_miss: FILL_I
2. Else d_miss: FILL_D
3. Else d_wr_req: WRITE
4. Else i_miss: FILL_I
5. Else IDLE

Fairness flag i_first:
- Set when an FILL_D or WRITE operation completes while i_miss=1.
- Cleared on FILL_I entry.
- Guarantees the I-fill waits behind at most one D operation.

On grant:
- Latch base = addr with the low log2(WORDS_PER_BLOCK*2) bits zeroed.
- Clear issue_cnt and ret_cnt.

FILL_x:
- Cycles 0..WORDS_PER_BLOCK-1 after entry: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments.
- Each cycle with mem_data_valid=1:
  - x_data_we=1, fill_addr=base+2*ret_cnt; ret_cnt increments.
- On the last valid (ret_cnt=WORDS_PER_BLOCK-1): x_tag_we=1 in the same cycle and the operation completes.
- Total dwell is WORDS_PER_BLOCK+MEM_LAT cycles (12 with defaults).

WRITE: a single cycle with:
- mem_en=1, mem_wr=1
- mem_addr=d_wr_addr, mem_wdata=d_wr_data
- wr_ack=1
- Then the operation completes.

Other rules:
- mem_data_valid is ignored outside FILL states, including stale returns after reset.
- Requests arriving mid-operation wait; no preemption.
- Stalls (combinational):
  - i_stall = i_miss & ~i_tag_we
  - d_stall = (d_miss & ~d_tag_we) | (d_wr_req & ~wr_ack)
- A miss is deasserted by the cache once its tag is written. The arbiter must not re-grant the same requester on the completing edge unless its miss is still asserted on the cycle after tag_we. To guarantee this, the grant evaluation at completion excludes the completing requester.
- Back-to-back grants are allowed: a new operation's first mem_en is in the cycle after the completion cycle.

Test Plan:
1. I-only: i_miss=1, i_miss_addr=0x1234 from IDLE.
   - mem_addr 0x1230,0x1232,...,0x123E on 8 consecutive cycles starting 1 cycle after request.
   - 8 i_data_we pulses with fill_addr 0x1230..0x123E.
   - i_tag_we on the 12th FILL_I cycle.
   - i_stall falls in that cycle; no d_* enables.
2. Simultaneous: i_miss (0x0100) and d_miss (0x2008) in the same cycle.
   - FILL_D first: mem_addr 0x2000..0x200E.
   - Then FILL_I at 0x0100 starting the cycle after d_tag_we.
3. Write during fill: d_wr_req (0x0040, 0xBEEF) raised in cycle 3 of FILL_I.
   - No mem_wr until i_tag_we.
   - Next cycle: mem_en=mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, wr_ack=1.
4. Starvation: d_miss pulses (a new miss asserted the cycle after each d_tag_we) while i_miss is held.
   - After the first FILL_D completes, FILL_I is granted before the second D miss.
5. Reset mid-fill: rst_n=0 in cycle 6 of FILL_D.
   - All outputs 0 asynchronously and busy=0.
   - After release with no requests: stays IDLE, ignores late mem_data_valid, asserts no *_we.
6. Write idle: d_wr_req alone.
   - wr_ack for exactly 1 cycle, d_stall drops in that cycle, busy returns to 0 on the following cycle.
